// File: rtl/mux8x1_using_2x1_pkg.sv
// Shared constants and types for the 8:1 mux-tree block.
package mux8x1_using_2x1_pkg;
    localparam int N_LANES    = 8;
    localparam int SEL_W      = 3;
    localparam int DEF_DATA_W = 1;

    typedef logic [DEF_DATA_W-1:0] lane_t;
endpackage

// File: rtl/mux8x1_using_2x1_if.sv
// Select/data/result bundle of the 8:1 mux; master drives sel and in, slave returns out.
interface mux8x1_using_2x1_if
    import mux8x1_using_2x1_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [SEL_W-1:0]          sel;
    logic [N_LANES*DATA_W-1:0] in;
    logic [DATA_W-1:0]         out;

    modport master (output sel, output in, input out);
    modport slave  (input sel, input in, output out);
endinterface

// File: rtl/mux8x1_using_2x1_mux2x1.sv
// Combinational 2:1 mux, the leaf cell of the tree.
module mux2x1 #(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              s,
    output logic [DATA_W-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/mux8x1_using_2x1.sv
// 8:1 mux built as a 4-2-1 tree of 2:1 muxes with a registered output and
// optional stage registers after levels 0 and 1.
module mux8x1_using_2x1
    import mux8x1_using_2x1_pkg::*;
#(
    parameter int                DATA_W    = 1,
    parameter int                PIPELINE  = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic                clk,
    input logic                rst,
    mux8x1_using_2x1_if.slave  bus
);
    logic [N_LANES-1:0][DATA_W-1:0] lane;
    logic [3:0][DATA_W-1:0]         l0, l0_q;
    logic [1:0][DATA_W-1:0]         l1, l1_q;
    logic [DATA_W-1:0]              l2;
    logic [SEL_W-1:1]               sel_s1;  // sel bits seen by level 1 (and 2)
    logic                           sel_s2;  // sel bit seen by level 2
    logic [DATA_W-1:0]              out_q;

    assign lane = bus.in;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_l0
            mux2x1 #(.DATA_W(DATA_W)) u_mux (
                .a(lane[2*k]), .b(lane[2*k+1]), .s(bus.sel[0]), .y(l0[k])
            );
        end

        for (genvar j = 0; j < 2; j++) begin : g_l1
            mux2x1 #(.DATA_W(DATA_W)) u_mux (
                .a(l0_q[2*j]), .b(l0_q[2*j+1]), .s(sel_s1[1]), .y(l1[j])
            );
        end

        if (PIPELINE != 0) begin : g_pipe
            // Upper sel bits ride with the data so each result uses its own select.
            always_ff @(posedge clk) begin
                if (rst) begin
                    l0_q   <= {4{RESET_VAL}};
                    sel_s1 <= '0;
                    l1_q   <= {2{RESET_VAL}};
                    sel_s2 <= 1'b0;
                end else begin
                    l0_q   <= l0;
                    sel_s1 <= bus.sel[SEL_W-1:1];
                    l1_q   <= l1;
                    sel_s2 <= sel_s1[2];
                end
            end
        end else begin : g_comb
            assign l0_q   = l0;
            assign sel_s1 = bus.sel[SEL_W-1:1];
            assign l1_q   = l1;
            assign sel_s2 = sel_s1[2];
        end
    endgenerate

    mux2x1 #(.DATA_W(DATA_W)) u_l2 (
        .a(l1_q[0]), .b(l1_q[1]), .s(sel_s2), .y(l2)
    );

    always_ff @(posedge clk) begin
        if (rst) out_q <= RESET_VAL;
        else     out_q <= l2;
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_mux8x1_using_2x1.sv
// Directed bench: three mux instances (1b flat, 1b pipelined, 4b pipelined) checked via scoreboard queues.
module tb_mux8x1_using_2x1;
    import mux8x1_using_2x1_pkg::*;

    localparam logic [3:0] RV2 = 4'hA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    lane_t      q0[$];
    lane_t      q1[$];
    logic [3:0] q2[$];

    mux8x1_using_2x1_if #(.DATA_W(1)) b0 ();
    mux8x1_using_2x1_if #(.DATA_W(1)) b1 ();
    mux8x1_using_2x1_if #(.DATA_W(4)) b2 ();

    mux8x1_using_2x1 #(.DATA_W(1), .PIPELINE(0), .RESET_VAL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mux8x1_using_2x1 #(.DATA_W(1), .PIPELINE(1), .RESET_VAL(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mux8x1_using_2x1 #(.DATA_W(4), .PIPELINE(1), .RESET_VAL(RV2))  dut2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, push expectations, then compare after the edge.
    task automatic step(input logic r, input logic [2:0] s, input logic [7:0] d8, input logic [31:0] d32);
        rst = r;
        b0.sel = s; b0.in = d8;
        b1.sel = s; b1.in = d8;
        b2.sel = s; b2.in = d32;
        if (r) begin
            q0.delete(); q1.delete(); q2.delete();
            q0.push_back(1'b0);
            repeat (3) begin
                q1.push_back(1'b0);
                q2.push_back(RV2);
            end
        end else begin
            q0.push_back(d8[s]);
            q1.push_back(d8[s]);
            q2.push_back(d32[s*4 +: 4]);
        end
        @(posedge clk);
        #1;
        chk("p0_w1", {3'b0, b0.out}, {3'b0, q0.pop_front()});
        chk("p1_w1", {3'b0, b1.out}, {3'b0, q1.pop_front()});
        chk("p1_w4", b2.out, q2.pop_front());
    endtask

    initial begin
        b0.sel = '0; b0.in = '0;
        b1.sel = '0; b1.in = '0;
        b2.sel = '0; b2.in = '0;
        @(negedge clk);

        // reset with all lanes high, then release
        step(1'b1, 3'd7, 8'hFF, 32'hFFFF_FFFF);
        step(1'b1, 3'd7, 8'hFF, 32'hFFFF_FFFF);
        repeat (3) step(1'b0, 3'd7, 8'hFF, 32'h7654_3210);

        // sel stepped across a sparse pattern
        step(1'b0, 3'd0, 8'b0000_0101, 32'h7654_3210);
        step(1'b0, 3'd1, 8'b0000_0101, 32'h7654_3210);
        step(1'b0, 3'd2, 8'b0000_0101, 32'h7654_3210);

        // exhaustive sel against low-nibble patterns
        for (int v = 0; v < 16; v++)
            for (int s = 0; s < 8; s++)
                step(1'b0, 3'(s), 8'(v), $urandom());

        // walking one: hit then neighbour miss
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'(k), 8'(1 << k), 32'(4'hF << (4*k)));
            step(1'b0, 3'((k + 1) % 8), 8'(1 << k), 32'(4'hF << (4*k)));
        end

        // back-to-back select toggling, reset mid-stream, resume
        step(1'b0, 3'd7, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd0, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd7, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd0, 8'b1000_0000, 32'h7654_3210);
        step(1'b1, 3'd7, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd7, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd0, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd7, 8'b1000_0000, 32'h7654_3210);
        step(1'b0, 3'd0, 8'b1000_0000, 32'h7654_3210);

        // wide lanes
        step(1'b0, 3'd5, 8'h00, 32'h7654_3210);
        step(1'b0, 3'd2, 8'h00, 32'hDEAD_BEEF);
        step(1'b0, 3'd7, 8'h00, 32'hCAFE_F00D);

        // drain in-flight results
        repeat (3) step(1'b0, 3'd0, 8'h00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
